// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned REGW_DEFAULT = 5;

    // funct3 encoding of the M-extension operations
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    // Divide/remainder ops all have funct3[2] set
    function automatic logic is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
interface muldiv_if #(
    parameter int unsigned XLEN = muldiv_pkg::XLEN_DEFAULT,
    parameter int unsigned REGW = muldiv_pkg::REGW_DEFAULT
);
    logic            valid_i;
    logic            ready_o;
    logic [2:0]      op_i;
    logic [XLEN-1:0] opa_i;
    logic [XLEN-1:0] opb_i;
    logic [REGW-1:0] rd_i;
    logic            flush_i;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    logic [REGW-1:0] waddr_o;

    // Execute stage side
    modport master (
        output valid_i, op_i, opa_i, opb_i, rd_i, flush_i,
        input  ready_o, valid_o, result_o, waddr_o
    );

    // Mul/div unit side
    modport slave (
        input  valid_i, op_i, opa_i, opb_i, rd_i, flush_i,
        output ready_o, valid_o, result_o, waddr_o
    );
endinterface

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
module muldiv_div_step #(
    parameter int unsigned XLEN = muldiv_pkg::XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Partial remainder always stays below 2*divisor, so diff[XLEN] is the borrow
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, dvs};
        if (!diff[XLEN]) begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = shifted[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, sign fix-up, single-cycle result pulse.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply, divide unchanged.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned REGW = REGW_DEFAULT
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    muldiv_if.slave bus
);
    localparam int unsigned     CNTW     = $clog2(XLEN);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e   state_q, state_d;
    muldiv_op_e      op_in, op_q;
    logic [CNTW-1:0] cnt_q;
    logic [XLEN-1:0] hi_q, lo_q, opd_q;
    logic            negq_q, negr_q;
    logic [REGW-1:0] rd_q;

    logic            valid_q, ready_q;
    logic [XLEN-1:0] result_q;
    logic [REGW-1:0] waddr_q;
    logic            valid_d, ready_d;
    logic [XLEN-1:0] result_d;
    logic [REGW-1:0] waddr_d;

    logic            accept, sign_a, sign_b, div_zero, div_ovf, special;
    logic [XLEN-1:0] a_mag, b_mag, special_res;
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] div_rem_n, div_quo_n;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0] quo_s, rem_s, fix_res;

    assign op_in  = muldiv_op_e'(bus.op_i);
    // ready_q is high exactly in IDLE; a flush in IDLE blocks the accept
    assign accept = bus.valid_i && ready_q && !bus.flush_i;

    assign sign_a   = is_signed_a(op_in) && bus.opa_i[XLEN-1];
    assign sign_b   = is_signed_b(op_in) && bus.opb_i[XLEN-1];
    assign a_mag    = sign_a ? (XLEN'(0) - bus.opa_i) : bus.opa_i;
    assign b_mag    = sign_b ? (XLEN'(0) - bus.opb_i) : bus.opb_i;
    assign div_zero = is_div(op_in) && (bus.opb_i == '0);
    assign div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM))
                      && (bus.opa_i == INT_MIN) && (bus.opb_i == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    // Sign-extended operands give the low 2*XLEN bits of the 33x33 signed product
    assign fast_a    = {{XLEN{sign_a}}, bus.opa_i};
    assign fast_b    = {{XLEN{sign_b}}, bus.opb_i};
    assign fast_prod = fast_a * fast_b;
`endif

    // Results known at accept time: divide corner cases (and fast multiply)
    always_comb begin
        special     = div_zero || div_ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = ((op_in == OP_DIV) || (op_in == OP_DIVU)) ? '1 : bus.opa_i;
        end else if (div_ovf) begin
            special_res = (op_in == OP_DIV) ? INT_MIN : '0;
        end
`ifdef MULDIV_FAST_MUL_EN
        if (!is_div(op_in)) begin
            special     = 1'b1;
            special_res = (op_in == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    // Shift-add multiply step: hi accumulates, lo holds the multiplier shifting out
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : (XLEN+1)'(0));

    muldiv_div_step #(.XLEN(XLEN)) u_div_step (
        .rem      (hi_q),
        .quo      (lo_q),
        .dvs      (opd_q),
        .rem_next (div_rem_n),
        .quo_next (div_quo_n)
    );

    // Sign correction of the raw magnitude results
    always_comb begin
        prod_s = negq_q ? ((2*XLEN)'(0) - {hi_q, lo_q}) : {hi_q, lo_q};
        quo_s  = negq_q ? (XLEN'(0) - lo_q) : lo_q;
        rem_s  = negr_q ? (XLEN'(0) - hi_q) : hi_q;
        case (op_q)
            OP_MUL:                        fix_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_res = quo_s;
            default:                       fix_res = rem_s;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (bus.flush_i)             state_d = ST_IDLE;
                else if (cnt_q == CNT_LAST)  state_d = ST_FIX;
            end
            ST_FIX:  state_d = bus.flush_i ? ST_IDLE : ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next values; result/waddr only change on entry to DONE
    always_comb begin
        valid_d  = (state_d == ST_DONE);
        ready_d  = (state_d == ST_IDLE);
        result_d = result_q;
        waddr_d  = waddr_q;
        if ((state_q == ST_IDLE) && accept && special) begin
            result_d = special_res;
            waddr_d  = bus.rd_i;
        end else if ((state_q == ST_FIX) && !bus.flush_i) begin
            result_d = fix_res;
            waddr_d  = rd_q;
        end
    end

    // Output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            result_q <= '0;
            waddr_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            result_q <= result_d;
            waddr_q  <= waddr_d;
        end
    end

    // Operand capture at accept and one iteration per CALC cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q   <= OP_MUL;
            rd_q   <= '0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opd_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && accept) begin
            op_q   <= op_in;
            rd_q   <= bus.rd_i;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= is_div(op_in) ? a_mag : b_mag;
            opd_q  <= is_div(op_in) ? b_mag : a_mag;
            negq_q <= sign_a ^ sign_b;
            negr_q <= sign_a;
        end else if (state_q == ST_CALC) begin
            cnt_q <= cnt_q + CNTW'(1);
            if (is_div(op_q)) begin
                hi_q <= div_rem_n;
                lo_q <= div_quo_n;
            end else begin
                hi_q <= mul_sum[XLEN:1];
                lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
            end
        end
    end

    assign bus.valid_o  = valid_q;
    assign bus.ready_o  = ready_q;
    assign bus.result_o = result_q;
    assign bus.waddr_o  = waddr_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed self-checking bench for muldiv_iter.
module tb_muldiv_iter;
    import muldiv_pkg::*;

    localparam int ITER_LAT = 34;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b1;
    int   tests  = 0;
    int   fails  = 0;

    muldiv_if #(.XLEN(32), .REGW(5)) bus ();

    muldiv_iter #(.XLEN(32), .REGW(5)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op, measure edges from accept (accept edge = 1) to valid_o
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat);
        int   lat;
        logic ready_bad;
        @(negedge clk_i);
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.opa_i   = a;
        bus.opb_i   = b;
        bus.rd_i    = rd;
        @(posedge clk_i); #1;
        bus.valid_i = 1'b0;
        lat = 1;
        ready_bad = 1'b0;
        while (bus.valid_o !== 1'b1 && lat < 100) begin
            if (bus.ready_o !== 1'b0) ready_bad = 1'b1;
            @(posedge clk_i); #1;
            lat++;
        end
        if (bus.ready_o !== 1'b0) ready_bad = 1'b1;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, bus.result_o, exp_res);
        check({tag, " waddr"}, 32'(bus.waddr_o), 32'(rd));
        check({tag, " ready low while busy"}, 32'(ready_bad), 32'd0);
        @(posedge clk_i); #1;
        check({tag, " valid one cycle"}, 32'(bus.valid_o), 32'd0);
        check({tag, " ready after"}, 32'(bus.ready_o), 32'd1);
    endtask

    initial begin
        int seen;
        int gap;
        bus.valid_i = 1'b0;
        bus.op_i    = 3'd0;
        bus.opa_i   = '0;
        bus.opb_i   = '0;
        bus.rd_i    = '0;
        bus.flush_i = 1'b0;

        // Reset state
        #1 rst_ni = 1'b0;
        #1;
        check("reset ready", 32'(bus.ready_o), 32'd1);
        check("reset valid", 32'(bus.valid_o), 32'd0);
        check("reset result", bus.result_o, 32'd0);
        check("reset waddr", 32'(bus.waddr_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // Multiplies
        run_op("MUL 7*-3",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, MUL_LAT);
        run_op("MULHU -1*-1", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, MUL_LAT);
        run_op("MULH -1*-1",  3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000, MUL_LAT);
        run_op("MULHSU",      3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, MUL_LAT);
        run_op("MUL -1*-1",   3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'h00000001, MUL_LAT);

        // Divides
        run_op("DIV -7/2",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD, ITER_LAT);
        run_op("REM -7/2",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF, ITER_LAT);
        run_op("DIVU 100/7",  3'd5, 32'd100,      32'd7,        5'd8,  32'h0000000E, ITER_LAT);
        run_op("REMU 100/7",  3'd7, 32'd100,      32'd7,        5'd9,  32'h00000002, ITER_LAT);

        // Divide corner cases
        run_op("DIVU 5/0",    3'd5, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 1);
        run_op("REM 5/0",     3'd6, 32'd5,        32'd0,        5'd11, 32'h00000005, 1);
        run_op("DIV ovf",     3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd0,  32'h80000000, 1);
        run_op("REM ovf",     3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000, 1);

        // Flush at CALC cnt=10
        @(negedge clk_i);
        bus.valid_i = 1'b1; bus.op_i = 3'd4; bus.opa_i = 32'd1000; bus.opb_i = 32'd3; bus.rd_i = 5'd13;
        @(posedge clk_i); #1;
        bus.valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        bus.flush_i = 1'b1;
        @(posedge clk_i); #1;
        bus.flush_i = 1'b0;
        check("flush ready", 32'(bus.ready_o), 32'd1);
        check("flush valid", 32'(bus.valid_o), 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (bus.valid_o === 1'b1) seen++;
        end
        check("flush no valid", 32'(seen), 32'd0);

        // Reset at cnt=20
        @(negedge clk_i);
        bus.valid_i = 1'b1; bus.op_i = 3'd4; bus.opa_i = 32'd1000; bus.opb_i = 32'd3; bus.rd_i = 5'd14;
        @(posedge clk_i); #1;
        bus.valid_i = 1'b0;
        repeat (20) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("midop reset valid", 32'(bus.valid_o), 32'd0);
        check("midop reset result", bus.result_o, 32'd0);
        check("midop reset waddr", 32'(bus.waddr_o), 32'd0);
        check("midop reset ready", 32'(bus.ready_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (bus.valid_o === 1'b1) seen++;
        end
        check("reset no valid", 32'(seen), 32'd0);

        // Back-to-back with valid_i held high
        @(negedge clk_i);
        bus.valid_i = 1'b1; bus.op_i = 3'd5; bus.opa_i = 32'd100; bus.opb_i = 32'd7; bus.rd_i = 5'd3;
        @(posedge clk_i); #1;
        bus.op_i = 3'd0; bus.opa_i = 32'd6; bus.opb_i = 32'd7; bus.rd_i = 5'd9;
        seen = 1;
        while (bus.valid_o !== 1'b1 && seen < 100) begin
            @(posedge clk_i); #1;
            seen++;
        end
        check("b2b first latency", 32'(seen), 32'(ITER_LAT));
        check("b2b first result", bus.result_o, 32'h0000000E);
        check("b2b first waddr", 32'(bus.waddr_o), 32'd3);
        gap = 0;
        do begin
            @(posedge clk_i); #1;
            gap++;
        end while (bus.valid_o !== 1'b1 && gap < 100);
        bus.valid_i = 1'b0;
        check("b2b gap", 32'(gap), 32'(1 + MUL_LAT));
        check("b2b second result", bus.result_o, 32'h0000002A);
        check("b2b second waddr", 32'(bus.waddr_o), 32'd9);
        @(posedge clk_i); #1;
        check("b2b idle", 32'(bus.valid_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
